// File: rtl/kws_linear_pkg.sv
// Shared constants and types for the KWS linear-layer weight streamer.
// Weights are signed 1.7.24 fixed point.
package kws_linear_pkg;

    localparam int KWS_DATA_W       = 32;
    localparam int KWS_IN_FEATURES  = 40;
    localparam int KWS_OUT_FEATURES = 10;

    localparam int FRAC_BITS = 24;
    localparam int INT_BITS  = 7;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } lws_state_e;

    // Integer value to 1.7.24 weight word.
    function automatic logic [KWS_DATA_W-1:0] int_to_fx(input int v);
        return KWS_DATA_W'(v) << FRAC_BITS;
    endfunction

endpackage

// File: rtl/linear_weight_streamer_if.sv
// Valid/ready weight stream from the streamer (master) to the MAC engine (slave).
interface linear_weight_streamer_if
    import kws_linear_pkg::*;
#(
    parameter int DATA_W = KWS_DATA_W,
    parameter int COL_W  = $clog2(KWS_IN_FEATURES)
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [COL_W-1:0]  out_col;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/linear_weight_streamer_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle memory read latency under backpressure.
// The head entry only changes on a pop, so the output stays stable while stalled.
module weight_skid_fifo #(
    parameter int W = 39
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] ent_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                ent_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o  = ent_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/linear_weight_streamer.sv
// Run-time loadable weight store that streams one output neuron's weight row
// to the linear MAC engine over a valid/ready interface.
module linear_weight_streamer
    import kws_linear_pkg::*;
#(
    parameter int DATA_W       = KWS_DATA_W,
    parameter int IN_FEATURES  = KWS_IN_FEATURES,
    parameter int OUT_FEATURES = KWS_OUT_FEATURES,
    parameter int ADDR_W       = $clog2(IN_FEATURES * OUT_FEATURES),
    parameter int ROW_W        = $clog2(OUT_FEATURES),
    parameter int COL_W        = $clog2(IN_FEATURES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    input  logic [ROW_W-1:0]  row,
    output logic              start_err,
    output logic              busy,
    output logic              done,
    linear_weight_streamer_if.master out_if
);

    localparam int DEPTH = IN_FEATURES * OUT_FEATURES;
    localparam int PW    = DATA_W + COL_W + 1;

    localparam logic [ADDR_W:0]   DEPTH_C      = (ADDR_W + 1)'(DEPTH);
    localparam logic [ROW_W:0]    ROWS_C       = (ROW_W + 1)'(OUT_FEATURES);
    localparam logic [COL_W:0]    COLS_C       = (COL_W + 1)'(IN_FEATURES);
    localparam logic [COL_W-1:0]  LAST_COL_C   = COL_W'(IN_FEATURES - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE_C = ADDR_W'(IN_FEATURES);

    lws_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [COL_W:0]    col_rd_q, col_rd_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_pend_q;
    logic [COL_W-1:0]  rd_col_q;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    logic              wr_ok;
    logic              start_ok;
    logic              wr_err_q;
    logic              start_err_q;

    logic [PW-1:0]     fifo_head;
    logic [1:0]        fifo_count;
    logic              stream_valid;
    logic              pop;
    logic [2:0]        slots;

    assign busy     = (state_q == STREAM);
    assign done     = (state_q == DONE);
    assign wr_ok    = wr_en && ({1'b0, wr_addr} < DEPTH_C) && !busy;
    assign start_ok = start && (state_q == IDLE) && ({1'b0, row} < ROWS_C);
    assign rd_addr  = base_q + ADDR_W'(col_rd_q);

    // Memory is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            col_rd_q    <= '0;
            rd_pend_q   <= 1'b0;
            rd_col_q    <= '0;
            wr_err_q    <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            col_rd_q    <= col_rd_d;
            rd_pend_q   <= rd_en;
            rd_col_q    <= col_rd_q[COL_W-1:0];
            wr_err_q    <= wr_en && !wr_ok;
            start_err_q <= start && !start_ok;
        end
    end

    // Slots still claimed after this cycle's pop; a read is issued only if the
    // FIFO can take its data, which keeps one beat per cycle without overflow.
    assign slots = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, pop};

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        col_rd_d = col_rd_q;
        rd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    base_d   = ADDR_W'(row) * ROW_STRIDE_C;
                    col_rd_d = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if ((col_rd_q < COLS_C) && (slots < 3'd2)) begin
                    rd_en    = 1'b1;
                    col_rd_d = col_rd_q + 1'b1;
                end
                if (pop && fifo_head[0]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    weight_skid_fifo #(
        .W (PW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_pend_q),
        .push_data_i ({rd_data_q, rd_col_q, (rd_col_q == LAST_COL_C)}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign stream_valid     = busy && (fifo_count != 2'd0);
    assign pop              = stream_valid && out_if.out_ready;
    assign out_if.out_valid = stream_valid;
    assign out_if.out_data  = fifo_head[PW-1 -: DATA_W];
    assign out_if.out_col   = fifo_head[COL_W:1];
    assign out_if.out_last  = fifo_head[0] && stream_valid;
    assign wr_err           = wr_err_q;
    assign start_err        = start_err_q;

endmodule
